mux8x1_rr_sched: RTL and testbench
==================================

MUX8X1_RR_SCHED -- requirements
Module: mux8x1_rr_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter BURST_LEN, default 4, legal range 1..16: the maximum number of beats per grant.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port req, input, 8: request from requester k on bit k; level-sensitive.
REQ-006 Port din, input, 8: data bit from requester k on bit k (channel inputs I0..I7).
REQ-007 Port sel, output, 3: registered channel select; sel[2:0] = S2,S1,S0.
REQ-008 Port gnt, output, 8: registered one-hot grant; all zero when idle.
REQ-009 Port y, output, 1: muxed channel output.
REQ-010 Port busy, output, 1: registered; high while a grant is held.
REQ-011 Port last, output, 1: high on the final counted beat of a full-length burst.

Function
REQ-012 The FSM SHALL have two states: IDLE (no owner) and BUSY (owner = sel).
REQ-013 IDLE: if req != 0 at a rising edge, the winner SHALL be granted at that edge (gnt, sel, busy valid in the next cycle); if req == 0, the FSM SHALL stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: search starts at index ptr and ascends modulo 8 (7 wraps to 0); the first set req bit wins.
REQ-015 On grant: beat counter SHALL be 0; gnt = 1<<winner; sel = winner; busy = 1.
REQ-016 BUSY: a cycle with req[sel] = 1 SHALL be a beat; at its rising edge the counter SHALL increment.
REQ-017 last SHALL equal busy & req[sel] & (count == BURST_LEN-1), combinationally.
REQ-018 Burst end SHALL occur at the edge of the last beat, or at any edge where busy = 1 and req[sel] = 0 (early release; last not asserted).
REQ-019 At burst end, ptr SHALL become (sel+1) mod 8, making the releasing owner lowest priority.
REQ-020 Back-to-back re-arbitration at burst end: if any req bit is set, evaluated with the updated ptr, the new winner SHALL be granted at the same edge (no idle cycle); otherwise the FSM SHALL return to IDLE with gnt = 0 and busy = 0.
REQ-021 When the same owner is the only requester at burst end, it SHALL be re-granted immediately with the counter cleared.
REQ-022 Request changes from non-owners during BUSY SHALL NOT affect sel, gnt or the counter.
REQ-023 y SHALL equal busy & din[sel], combinationally, and SHALL be 0 when idle.
REQ-024 BURST_LEN = 1 SHALL give one beat per grant, with last = 1 on every granted beat that has req[sel] = 1.
REQ-025 gnt SHALL always be zero or one-hot, and gnt[sel] SHALL equal busy.

Reset
REQ-026 While rst = 1 (asynchronous): state = IDLE, sel = 0, gnt = 0, busy = 0, ptr = 0, count = 0; consequently y = 0 and last = 0.
REQ-027 Reset asserted mid-burst SHALL abort the burst immediately, with no further beats.
REQ-028 After release, arbitration SHALL restart from ptr = 0 at the first rising edge with rst = 0.

Verification
REQ-029 Directed scenario, reset then single requester: req = 8'h04 held, BURST_LEN = 4 -> one cycle later sel = 2, gnt = 8'h04, busy = 1; last on 4th beat; re-granted to 2 with count reset.
REQ-030 Directed scenario, round robin: req = 8'hFF held, BURST_LEN = 4 -> grant sequence 0,1,2,...,7,0; each burst 4 cycles; no idle cycle between bursts.
REQ-031 Directed scenario, early release: owner 3 drops req after 2 beats, req[5] = 1 -> gnt moves to 8'h20 at the next edge; last never asserted for owner 3; ptr = 4.
REQ-032 Directed scenario, wrap: owner 7 finishes, req = 8'h81 -> next grant goes to 0, not 7.
REQ-033 Directed scenario, datapath: owner 6 granted, din = 8'h40 -> y = 1; din = 8'hBF -> y = 0; idle with din = 8'hFF -> y = 0.
REQ-034 Directed scenario, reset mid-burst: rst pulsed during beat 2 of owner 5 -> gnt = 0 and busy = 0 without waiting for a clock edge; with req = 8'h22 after release, the first grant goes to 1.

Source files
------------

// File: rtl/mux8x1_rr_sched_if.sv
// ----------------------------------------------------------------------------
// mux8x1_rr_sched_if
// Bundles the request/data inputs and the grant/select/mux outputs of the
// 8-way round-robin burst scheduler. Clock and reset stay plain module ports.
//
// Signals
//   req  [7:0] : level-sensitive request, one bit per requester
//   din  [7:0] : one data bit per requester (channels I0..I7)
//   sel  [2:0] : registered channel select of the current owner
//   gnt  [7:0] : registered one-hot grant, zero when idle
//   y          : data bit of the selected channel, zero when idle
//   busy       : registered, high while a grant is held
//   last       : final counted beat of a full-length burst
//
// Modports
//   master : requester / bench side (drives req, din)
//   slave  : scheduler side (drives sel, gnt, y, busy, last)
// ----------------------------------------------------------------------------
interface mux8x1_rr_sched_if;
    logic [7:0] req;
    logic [7:0] din;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       y;
    logic       busy;
    logic       last;

    modport master (
        output req,
        output din,
        input  sel,
        input  gnt,
        input  y,
        input  busy,
        input  last
    );

    modport slave (
        input  req,
        input  din,
        output sel,
        output gnt,
        output y,
        output busy,
        output last
    );
endinterface

// File: rtl/mux8x1_rr_sched.sv
// ----------------------------------------------------------------------------
// mux8x1_rr_sched
// 8:1 single-bit multiplexer whose select is driven by a round-robin burst
// arbiter. A granted requester keeps ownership for up to BURST_LEN beats
// (cycles with its request high) or until it drops its request; ownership
// then passes straight to the next requester above it, with no idle cycle.
//
// Parameters
//   BURST_LEN : maximum beats per grant, 1..16
//
// Ports
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave modport of mux8x1_rr_sched_if (req, din in; sel, gnt, y,
//          busy, last out)
// ----------------------------------------------------------------------------
module mux8x1_rr_sched #(
    parameter int BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux8x1_rr_sched_if.slave   bus
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_n;
    logic [2:0]       sel_q, sel_n;
    logic [2:0]       ptr_q, ptr_n;
    logic [7:0]       gnt_q, gnt_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    logic       busy;
    logic       beat;
    logic       at_last;
    logic       any_req;
    logic [2:0] arb_ptr;
    logic [2:0] winner;

    // First set request bit at or above p, wrapping 7 -> 0. Scanning from
    // the farthest offset down lets the nearest one overwrite the result.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        rr_pick = p;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    assign busy    = (state_q == BUSY);
    assign beat    = bus.req[sel_q];
    assign at_last = (cnt_q == LAST_CNT);
    assign any_req = |bus.req;

    // At burst end the pointer moves to sel+1 on the same edge as the
    // re-arbitration, so the search has to use that value rather than ptr_q.
    assign arb_ptr = busy ? (sel_q + 3'd1) : ptr_q;
    assign winner  = rr_pick(bus.req, arb_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            gnt_q   <= 8'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            sel_q   <= sel_n;
            ptr_q   <= ptr_n;
            gnt_q   <= gnt_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        sel_n   = sel_q;
        ptr_n   = ptr_q;
        gnt_n   = gnt_q;
        cnt_n   = cnt_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_n = BUSY;
                    sel_n   = winner;
                    gnt_n   = 8'd1 << winner;
                    cnt_n   = '0;
                end
            end

            BUSY: begin
                // Burst ends on the final beat or as soon as the owner lets go.
                if (!beat || at_last) begin
                    ptr_n = sel_q + 3'd1;
                    cnt_n = '0;
                    if (any_req) begin
                        sel_n = winner;
                        gnt_n = 8'd1 << winner;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 8'd0;
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
                gnt_n   = 8'd0;
                cnt_n   = '0;
            end
        endcase
    end

    assign bus.sel  = sel_q;
    assign bus.gnt  = gnt_q;
    assign bus.busy = busy;
    assign bus.y    = busy & bus.din[sel_q];
    assign bus.last = busy & beat & at_last;

endmodule

// File: tb/tb_mux8x1_rr_sched.sv
module tb_mux8x1_rr_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    // Packed observation: {sel[2:0], gnt[7:0], busy, last, y}
    logic [13:0] got_v;
    logic [13:0] exp_v;

    mux8x1_rr_sched_if a_if ();
    mux8x1_rr_sched_if b_if ();

    mux8x1_rr_sched #(.BURST_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    mux8x1_rr_sched #(.BURST_LEN(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] obs_a();
        return {a_if.sel, a_if.gnt, a_if.busy, a_if.last, a_if.y};
    endfunction

    function automatic logic [13:0] obs_b();
        return {b_if.sel, b_if.gnt, b_if.busy, b_if.last, b_if.y};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_if.req = 8'h00;
        b_if.req = 8'h00;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_if.req = 8'h00; a_if.din = 8'h00;
        b_if.req = 8'h00; b_if.din = 8'h00;
        step();
        got_v = obs_a(); exp_v = 14'h0;
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++; $display("FAIL reset_idle: got %h want %h", got_v, exp_v);
        end
        // Requests and data must not leak through while reset is held.
        a_if.req = 8'hFF; a_if.din = 8'hFF;
        b_if.req = 8'hFF; b_if.din = 8'hFF;
        step();
        got_v = obs_a(); exp_v = 14'h0;
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++; $display("FAIL reset_hold_a: got %h want %h", got_v, exp_v);
        end
        got_v = obs_b();
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++; $display("FAIL reset_hold_b: got %h want %h", got_v, exp_v);
        end
    endtask

    task automatic test_single();
        a_if.req = 8'h04; a_if.din = 8'h00;
        b_if.req = 8'h00; b_if.din = 8'h00;
        rst = 1'b0;
        step();
        got_v = obs_a(); exp_v = {3'd2, 8'h04, 1'b1, 1'b0, 1'b0};
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++; $display("FAIL single_grant: got %h want %h", got_v, exp_v);
        end
        for (int b = 1; b <= 3; b++) begin
            step();
            got_v = obs_a(); exp_v = {3'd2, 8'h04, 1'b1, (b == 3), 1'b0};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++; $display("FAIL single_beat%0d: got %h want %h", b + 1, got_v, exp_v);
            end
        end
        // Re-grant to the lone requester with the counter cleared.
        for (int b = 0; b <= 3; b++) begin
            step();
            got_v = obs_a(); exp_v = {3'd2, 8'h04, 1'b1, (b == 3), 1'b0};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++; $display("FAIL single_regrant_beat%0d: got %h want %h", b + 1, got_v, exp_v);
            end
        end
        a_if.req = 8'h00;
        step();
        got_v = obs_a(); exp_v = 14'h0;
        n_vec++;
        if (got_v[10:0] !== exp_v[10:0]) begin
            n_err++; $display("FAIL single_idle: got %h want %h", got_v[10:0], exp_v[10:0]);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        a_if.req = 8'hFF; a_if.din = 8'h00;
        for (int k = 0; k <= 8; k++) begin
            for (int b = 0; b <= 3; b++) begin
                step();
                got_v = obs_a();
                exp_v = {3'(k % 8), 8'(1 << (k % 8)), 1'b1, (b == 3), 1'b0};
                n_vec++;
                if (got_v !== exp_v) begin
                    n_err++; $display("FAIL rr_burst%0d_beat%0d: got %h want %h", k, b + 1, got_v, exp_v);
                end
            end
        end
        a_if.req = 8'h00;
        step();
        got_v = obs_a(); exp_v = 14'h0;
        n_vec++;
        if (got_v[10:0] !== exp_v[10:0]) begin
            n_err++; $display("FAIL rr_idle: got %h want %h", got_v[10:0], exp_v[10:0]);
        end
    endtask

    task automatic test_early_release();
        do_reset();
        a_if.req = 8'h08; a_if.din = 8'h00;
        for (int b = 0; b <= 2; b++) begin
            step();
            got_v = obs_a(); exp_v = {3'd3, 8'h08, 1'b1, 1'b0, 1'b0};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++; $display("FAIL early_owner3_cyc%0d: got %h want %h", b, got_v, exp_v);
            end
        end
        a_if.req = 8'h20;
        #1;
        got_v = obs_a(); exp_v = {3'd3, 8'h08, 1'b1, 1'b0, 1'b0};
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++; $display("FAIL early_drop_no_last: got %h want %h", got_v, exp_v);
        end
        step();
        got_v = obs_a(); exp_v = {3'd5, 8'h20, 1'b1, 1'b0, 1'b0};
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++; $display("FAIL early_handover: got %h want %h", got_v, exp_v);
        end
        a_if.req = 8'h00;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        a_if.req = 8'h80; a_if.din = 8'h00;
        step();
        a_if.req = 8'h81;
        for (int b = 1; b <= 3; b++) begin
            step();
            got_v = obs_a(); exp_v = {3'd7, 8'h80, 1'b1, (b == 3), 1'b0};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++; $display("FAIL wrap_owner7_beat%0d: got %h want %h", b + 1, got_v, exp_v);
            end
        end
        step();
        got_v = obs_a(); exp_v = {3'd0, 8'h01, 1'b1, 1'b0, 1'b0};
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++; $display("FAIL wrap_to0: got %h want %h", got_v, exp_v);
        end
        a_if.req = 8'h00;
        step();
    endtask

    task automatic test_datapath();
        do_reset();
        a_if.req = 8'h40; a_if.din = 8'h40;
        step();
        got_v = obs_a(); exp_v = {3'd6, 8'h40, 1'b1, 1'b0, 1'b1};
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++; $display("FAIL dp_y_high: got %h want %h", got_v, exp_v);
        end
        a_if.din = 8'hBF;
        #1;
        n_vec++;
        if (a_if.y !== 1'b0) begin
            n_err++; $display("FAIL dp_y_low: got %b want 0", a_if.y);
        end
        a_if.req = 8'h00;
        step();
        a_if.din = 8'hFF;
        #1;
        got_v = obs_a(); exp_v = 14'h0;
        n_vec++;
        if (got_v[10:0] !== exp_v[10:0]) begin
            n_err++; $display("FAIL dp_idle_y: got %h want %h", got_v[10:0], exp_v[10:0]);
        end
        a_if.din = 8'h00;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        a_if.req = 8'h20; a_if.din = 8'h20;
        step();
        step();
        got_v = obs_a(); exp_v = {3'd5, 8'h20, 1'b1, 1'b0, 1'b1};
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++; $display("FAIL rstmid_beat2: got %h want %h", got_v, exp_v);
        end
        rst = 1'b1;
        #1;
        got_v = obs_a(); exp_v = 14'h0;
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++; $display("FAIL rstmid_async_clear: got %h want %h", got_v, exp_v);
        end
        #2;
        rst = 1'b0;
        a_if.req = 8'h22; a_if.din = 8'h00;
        step();
        got_v = obs_a(); exp_v = {3'd1, 8'h02, 1'b1, 1'b0, 1'b0};
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++; $display("FAIL rstmid_restart: got %h want %h", got_v, exp_v);
        end
        a_if.req = 8'h00;
        step();
    endtask

    task automatic test_burst1();
        do_reset();
        b_if.req = 8'hFF; b_if.din = 8'h00;
        for (int k = 0; k <= 3; k++) begin
            step();
            got_v = obs_b(); exp_v = {3'(k), 8'(1 << k), 1'b1, 1'b1, 1'b0};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++; $display("FAIL b1_grant%0d: got %h want %h", k, got_v, exp_v);
            end
        end
        b_if.req = 8'hF7;
        #1;
        got_v = obs_b(); exp_v = {3'd3, 8'h08, 1'b1, 1'b0, 1'b0};
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++; $display("FAIL b1_no_beat: got %h want %h", got_v, exp_v);
        end
        step();
        got_v = obs_b(); exp_v = {3'd4, 8'h10, 1'b1, 1'b1, 1'b0};
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++; $display("FAIL b1_next: got %h want %h", got_v, exp_v);
        end
        b_if.req = 8'h00;
        step();
        got_v = obs_b(); exp_v = 14'h0;
        n_vec++;
        if (got_v[10:0] !== exp_v[10:0]) begin
            n_err++; $display("FAIL b1_idle: got %h want %h", got_v[10:0], exp_v[10:0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_early_release();
        test_wrap();
        test_datapath();
        test_reset_mid_burst();
        test_burst1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
